// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake movement and grid/render controllers.
package snake_pkg;

  typedef enum logic [1:0] {
    RIGHT = 2'd0,
    LEFT  = 2'd1,
    UP    = 2'd2,
    DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned GRID_SIZE = 32;
  localparam int unsigned CELL_SIZE = 16;

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    unique case (d)
      RIGHT:   o = LEFT;
      LEFT:    o = RIGHT;
      UP:      o = DOWN;
      default: o = UP;
    endcase
    return o;
  endfunction

  // One-hot strobe vector indexed by direction code: {down, up, left, right}.
  function automatic logic [3:0] dir_strobe(input dir_t d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/snake_move_ctrl_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CntLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          rise_q;

  // Level only follows the synchronized input after it disagrees for DEBOUNCE_CYCLES samples.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchronizer, debounce state and registered rising-edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b00;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      rise_q       <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], btn};
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      rise_q       <= level_q & ~level_prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/snake_move_ctrl.sv
// Snake move controller: debounced buttons -> validated, buffered, tick-paced move strobes.
module snake_move_ctrl
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned TICK_CYCLES     = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [1:0] dir,
  output logic       running
);

  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TickLast = TW'(TICK_CYCLES - 1);

  // Bit order: right, left, up, down, center.
  logic [4:0] btn_raw;
  logic [4:0] btn_rise;

  assign btn_raw = {btn_center, btn_down, btn_up, btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .rise (btn_rise[i])
    );
  end

  state_t        state_q, state_d;
  dir_t          dir_q, dir_d;
  dir_t          pend_dir_q, pend_dir_d;
  logic          pend_valid_q, pend_valid_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [3:0]    strobe_q, strobe_d;

  logic          has_press;
  dir_t          press_dir;
  dir_t          ref_dir;
  dir_t          commit_dir;
  logic          wrap;
  logic          center;

  assign center  = btn_rise[4];
  assign ref_dir = pend_valid_q ? pend_dir_q : dir_q;
  assign wrap    = (cnt_q == TickLast);

  // Pick a single direction edge per cycle: right > left > up > down.
  always_comb begin
    has_press = 1'b1;
    press_dir = RIGHT;
    if (btn_rise[0]) begin
      press_dir = RIGHT;
    end else if (btn_rise[1]) begin
      press_dir = LEFT;
    end else if (btn_rise[2]) begin
      press_dir = UP;
    end else if (btn_rise[3]) begin
      press_dir = DOWN;
    end else begin
      has_press = 1'b0;
    end
  end

  // FSM next state, tick counter, pending slot and move strobe generation.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    pend_dir_d   = pend_dir_q;
    pend_valid_d = pend_valid_q;
    cnt_d        = cnt_q;
    strobe_d     = 4'b0000;
    commit_dir   = pend_valid_q ? pend_dir_q : dir_q;
    unique case (state_q)
      IDLE: begin
        // LEFT would reverse the initial RIGHT heading; a center edge swallows the press.
        if (!center && has_press && press_dir != LEFT) begin
          state_d = RUN;
          dir_d   = press_dir;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (center) begin
          state_d = PAUSE;
        end else if (wrap) begin
          cnt_d        = '0;
          dir_d        = commit_dir;
          pend_valid_d = 1'b0;
          strobe_d     = dir_strobe(commit_dir);
          if (has_press && press_dir != commit_dir && press_dir != opposite(commit_dir)) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = press_dir;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
          if (has_press && press_dir != ref_dir && press_dir != opposite(ref_dir)) begin
            pend_valid_d = 1'b1;
            pend_dir_d   = press_dir;
          end
        end
      end
      PAUSE: begin
        if (center) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      dir_q        <= RIGHT;
      pend_dir_q   <= RIGHT;
      pend_valid_q <= 1'b0;
      cnt_q        <= '0;
      strobe_q     <= 4'b0000;
    end else begin
      state_q      <= state_d;
      dir_q        <= dir_d;
      pend_dir_q   <= pend_dir_d;
      pend_valid_q <= pend_valid_d;
      cnt_q        <= cnt_d;
      strobe_q     <= strobe_d;
    end
  end

  assign right   = strobe_q[0];
  assign left    = strobe_q[1];
  assign up      = strobe_q[2];
  assign down    = strobe_q[3];
  assign dir     = dir_q;
  assign running = (state_q == RUN);

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
module tb_snake_move_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_center = 1'b0;
  logic       up, down, left, right, running;
  logic [1:0] dir;

  int checks = 0;
  int failures = 0;
  int first_at;
  int log_q[$];
  int multi_cnt = 0;
  int idle_strobe_cnt = 0;

  always #5 clk = ~clk;

  snake_move_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES    (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_center(btn_center),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .dir       (dir),
    .running   (running)
  );

  // Advance n cycles, sampling at each falling edge; logs strobe codes (0=R,1=L,2=U,3=D).
  task automatic run_cycles(input int n);
    first_at = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (up | down | left | right) begin
        if (first_at == 0) first_at = i;
        if ($countones({up, down, left, right}) > 1) multi_cnt++;
        if (!running) idle_strobe_cnt++;
        if (right) log_q.push_back(0);
        else if (left) log_q.push_back(1);
        else if (up) log_q.push_back(2);
        else log_q.push_back(3);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    {btn_up, btn_down, btn_left, btn_right, btn_center} = 5'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", running); end
    checks++;
    if (dir !== 2'd0) begin failures++; $display("FAIL reset_dir got=%0d exp=0", dir); end
    checks++;
    if ({up, down, left, right} !== 4'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=0000", {up, down, left, right});
    end
    rst = 1'b0;
    log_q.delete();
    run_cycles(100);
    checks++;
    if (log_q.size() != 0) begin failures++; $display("FAIL idle_strobes got=%0d exp=0", log_q.size()); end
    checks++;
    if (running !== 1'b0 || dir !== 2'd0) begin
      failures++; $display("FAIL idle_state running=%b dir=%0d exp running=0 dir=0", running, dir);
    end
  endtask

  task automatic test_start_up();
    do_reset();
    btn_up = 1'b1;
    run_cycles(7);
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL start_early got=%b exp=0", running); end
    run_cycles(1);
    checks++;
    if (running !== 1'b1 || dir !== 2'd2) begin
      failures++; $display("FAIL start_up running=%b dir=%0d exp running=1 dir=2", running, dir);
    end
    log_q.delete();
    run_cycles(2);
    btn_up = 1'b0;
    run_cycles(30);
    checks++;
    if (log_q.size() != 4) begin failures++; $display("FAIL up_count got=%0d exp=4", log_q.size()); end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] != 2) begin failures++; $display("FAIL up_dir[%0d] got=%0d exp=2", i, log_q[i]); end
    end
    checks++;
    if (first_at != 6) begin failures++; $display("FAIL up_phase got=%0d exp=6", first_at); end
  endtask

  task automatic test_reversal();
    int exp_log[4] = '{0, 2, 1, 1};
    do_reset();
    btn_right = 1'b1;
    run_cycles(8);
    btn_right = 1'b0;
    log_q.delete();
    run_cycles(2);
    btn_left = 1'b1;
    run_cycles(8);
    btn_left = 1'b0;
    run_cycles(14);
    checks++;
    if (log_q.size() != 3 || dir !== 2'd0) begin
      failures++; $display("FAIL reverse_reject strobes=%0d dir=%0d exp strobes=3 dir=0", log_q.size(), dir);
    end
    for (int i = 0; i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] != 0) begin failures++; $display("FAIL reverse_dir[%0d] got=%0d exp=0", i, log_q[i]); end
    end
    log_q.delete();
    run_cycles(5);
    btn_up = 1'b1;
    run_cycles(4);
    btn_left = 1'b1;
    run_cycles(4);
    btn_up = 1'b0;
    run_cycles(4);
    btn_left = 1'b0;
    run_cycles(15);
    checks++;
    if (log_q.size() != 4) begin failures++; $display("FAIL turn_count got=%0d exp=4", log_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        checks++;
        if (log_q[i] != exp_log[i]) begin
          failures++; $display("FAIL turn_seq[%0d] got=%0d exp=%0d", i, log_q[i], exp_log[i]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    btn_down = 1'b1;
    run_cycles(8);
    btn_down = 1'b0;
    checks++;
    if (running !== 1'b1 || dir !== 2'd3) begin
      failures++; $display("FAIL bounce_start running=%b dir=%0d exp running=1 dir=3", running, dir);
    end
    for (int i = 0; i < 10; i++) begin
      btn_center = ~btn_center;
      run_cycles(2);
    end
    btn_center = 1'b1;
    run_cycles(10);
    btn_center = 1'b0;
    run_cycles(10);
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL bounce_single got=%b exp=0", running); end
    log_q.delete();
    run_cycles(20);
    checks++;
    if (log_q.size() != 0 || dir !== 2'd3) begin
      failures++; $display("FAIL bounce_paused strobes=%0d dir=%0d exp strobes=0 dir=3", log_q.size(), dir);
    end
  endtask

  task automatic test_pause();
    do_reset();
    btn_right = 1'b1;
    run_cycles(8);
    btn_right = 1'b0;
    log_q.delete();
    run_cycles(2);
    btn_center = 1'b1;
    run_cycles(8);
    btn_center = 1'b0;
    checks++;
    if (running !== 1'b0 || log_q.size() != 1) begin
      failures++; $display("FAIL pause_enter running=%b strobes=%0d exp running=0 strobes=1", running, log_q.size());
    end
    log_q.delete();
    run_cycles(2);
    btn_up = 1'b1;
    run_cycles(8);
    btn_up = 1'b0;
    run_cycles(10);
    checks++;
    if (log_q.size() != 0 || dir !== 2'd0) begin
      failures++; $display("FAIL pause_hold strobes=%0d dir=%0d exp strobes=0 dir=0", log_q.size(), dir);
    end
    btn_center = 1'b1;
    run_cycles(8);
    btn_center = 1'b0;
    checks++;
    if (running !== 1'b1) begin failures++; $display("FAIL pause_resume got=%b exp=1", running); end
    log_q.delete();
    run_cycles(7);
    checks++;
    if (first_at != 7) begin failures++; $display("FAIL resume_phase got=%0d exp=7", first_at); end
    checks++;
    if (log_q.size() != 1 || (log_q.size() == 1 && log_q[0] != 0)) begin
      failures++; $display("FAIL resume_dir strobes=%0d exp one right strobe", log_q.size());
    end
    run_cycles(8);
    checks++;
    if (first_at != 8) begin failures++; $display("FAIL resume_period got=%0d exp=8", first_at); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    btn_right = 1'b1;
    run_cycles(8);
    btn_right = 1'b0;
    btn_up = 1'b1;
    log_q.delete();
    run_cycles(8);
    btn_up = 1'b0;
    run_cycles(5);
    checks++;
    if (log_q.size() != 1 || running !== 1'b1) begin
      failures++; $display("FAIL pre_reset strobes=%0d running=%b exp strobes=1 running=1", log_q.size(), running);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (running !== 1'b0 || dir !== 2'd0 || {up, down, left, right} !== 4'b0) begin
      failures++; $display("FAIL mid_reset running=%b dir=%0d strobes=%b exp 0/0/0000",
                           running, dir, {up, down, left, right});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    log_q.delete();
    run_cycles(20);
    checks++;
    if (log_q.size() != 0 || running !== 1'b0) begin
      failures++; $display("FAIL post_reset strobes=%0d running=%b exp strobes=0 running=0", log_q.size(), running);
    end
  endtask

  task automatic test_priority();
    do_reset();
    btn_up = 1'b1;
    btn_left = 1'b1;
    run_cycles(8);
    {btn_up, btn_left} = 2'b00;
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL prio_left_start got=%b exp=0", running); end
    run_cycles(10);
    btn_center = 1'b1;
    btn_down = 1'b1;
    run_cycles(8);
    {btn_center, btn_down} = 2'b00;
    checks++;
    if (running !== 1'b0) begin failures++; $display("FAIL center_wins_idle got=%b exp=0", running); end
    run_cycles(10);
    btn_up = 1'b1;
    btn_down = 1'b1;
    run_cycles(8);
    {btn_up, btn_down} = 2'b00;
    checks++;
    if (running !== 1'b1 || dir !== 2'd2) begin
      failures++; $display("FAIL prio_up_down running=%b dir=%0d exp running=1 dir=2", running, dir);
    end
  endtask

  initial begin
    test_reset();
    test_start_up();
    test_reversal();
    test_bounce();
    test_pause();
    test_reset_mid();
    test_priority();
    checks++;
    if (multi_cnt != 0) begin failures++; $display("FAIL strobe_onehot got=%0d exp=0", multi_cnt); end
    checks++;
    if (idle_strobe_cnt != 0) begin
      failures++; $display("FAIL strobe_not_running got=%0d exp=0", idle_strobe_cnt);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
